// File: rtl/prefetch_ctrl.sv
// ----------------------------------------------------------------------------
// prefetch_ctrl
//
// Drives the instruction-prefetch side of the core: issues word-aligned fetch
// requests on the instruction bus, counts granted-but-unanswered requests,
// writes returned words into the prefetch FIFO and, on a branch, flushes the
// FIFO, redirects fetching and quietly drops every response that belongs to a
// request made before the branch.
//
// Ports
//   clk              clock
//   reset_n          synchronous active-low reset
//   fetch_en         new requests may be issued
//   branch_req       single-cycle redirect pulse
//   branch_addr      redirect target (bits [1:0] ignored)
//   instr_req        bus request
//   instr_addr       bus address (word aligned)
//   instr_gnt        bus accepts the current request
//   instr_rvalid     in-order response valid
//   instr_rdata      response data
//   fifo_clear       flush the prefetch FIFO (same cycle as branch_req)
//   fifo_wvalid      write instr_rdata into the FIFO
//   fifo_wdata       word to write
//   fifo_almost_full FIFO has no guaranteed room for more in-flight words
//   busy             requests in flight, words still to discard, or requesting
// ----------------------------------------------------------------------------
module prefetch_ctrl #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = 32'h0000_0080
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_en,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  instr_req,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_gnt,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  fifo_clear,
    output logic                  fifo_wvalid,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_almost_full,
    output logic                  busy
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0]   pend_target_q, pend_target_d;
    logic                    pend_q, pend_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic [CNT_W-1:0]        discard_q, discard_d;
    logic                    gnt_fire;
    logic                    rsp_fire;
    logic                    issue_ok;
    logic [ADDR_WIDTH-1:0]   branch_target;

    assign branch_target = {branch_addr[ADDR_WIDTH-1:2], 2'b00};
    assign instr_req     = (state_q == REQ);
    assign instr_addr    = fetch_addr_q;
    assign gnt_fire      = instr_req & instr_gnt;
    // A response with nothing in flight would be a bus error; never let it
    // underflow the counter.
    assign rsp_fire      = instr_rvalid & (outstanding_q != '0);

    assign fifo_clear  = branch_req;
    assign fifo_wvalid = instr_rvalid & (discard_q == '0) & ~branch_req;
    assign fifo_wdata  = instr_rdata;
    assign busy        = (outstanding_q != '0) | (discard_q != '0) | instr_req;

    // In-flight count after this cycle's grant and response.
    always_comb begin
        outstanding_d = outstanding_q;
        if (gnt_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + ONE;
        end else if (!gnt_fire && rsp_fire) begin
            outstanding_d = outstanding_q - ONE;
        end
    end

    // Issue decisions use the count as it will stand next cycle, so a request
    // presented next cycle can never push the in-flight count past the limit,
    // even when the current request is granted and no response returns.
    assign issue_ok = fetch_en & ~fifo_almost_full & ~branch_req &
                      (outstanding_d < MAX_CNT);

    // Everything in flight at the end of a branch cycle is stale. A request
    // stalled across a branch is only counted once it is actually granted.
    always_comb begin
        discard_d = discard_q;
        if (branch_req) begin
            discard_d = outstanding_d;
        end else begin
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - ONE;
            end
            if (pend_q && gnt_fire) begin
                discard_d = discard_d + ONE;
            end
        end
    end

    // A stalled request must keep its address until granted, so a branch that
    // lands during the stall is parked in pend_target and applied at the grant.
    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        if (branch_req) begin
            if (!instr_req || instr_gnt) begin
                fetch_addr_d = branch_target;
                pend_d       = 1'b0;
            end else begin
                pend_d        = 1'b1;
                pend_target_d = branch_target;
            end
        end else if (gnt_fire) begin
            fetch_addr_d = pend_q ? pend_target_q : fetch_addr_q + ADDR_WIDTH'(4);
            pend_d       = 1'b0;
        end
    end

    // REQ is left only on a grant, which keeps the bus request stable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_ok) state_d = REQ;
            REQ:     if (instr_gnt && !issue_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fetch_addr_q  <= BOOT_ADDR;
            pend_target_q <= '0;
            pend_q        <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            pend_target_q <= pend_target_d;
            pend_q        <= pend_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: doc/prefetch_ctrl.md
Name: prefetch_ctrl

Overview:
Sequences the instruction prefetch path: generates word-aligned fetch requests on the instruction bus and tracks outstanding transactions. Writes returned words into the prefetch FIFO, throttling on the FIFO's almost-full flag. On a branch it clears the FIFO, redirects the fetch address and silently discards responses belonging to requests issued before the branch. Sits between the core's IF stage (branch/enable) and the instruction memory port.

Parameters:
ADDR_WIDTH, 32, fetch address width
DATA_WIDTH, 32, instruction word width
MAX_OUTSTANDING, 2, max granted-but-unanswered bus requests (>=1)
BOOT_ADDR, 32'h0000_0080, fetch address after reset

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
fetch_en  input  1  fetching allowed; when low no new requests issue, outstanding ones complete
branch_req  input  1  single-cycle redirect pulse
branch_addr  input  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0)
instr_req  output  1  bus request
instr_addr  output  ADDR_WIDTH  bus address, word aligned
instr_gnt  input  1  bus accepts request this cycle
instr_rvalid  input  1  response valid (in request order, >=1 cycle after gnt)
instr_rdata  input  DATA_WIDTH  response data
fifo_clear  output  1  flush prefetch FIFO
fifo_wvalid  output  1  write response word into FIFO
fifo_wdata  output  DATA_WIDTH  = instr_rdata
fifo_almost_full  input  1  FIFO cannot guarantee space for further in-flight words
busy  output  1  outstanding count or discard count nonzero, or instr_req high

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n sampled on rising clk edge). Reset: fetch_addr=BOOT_ADDR, outstanding=0, discard=0, branch_pending=0, state IDLE. Outputs: instr_req=0, fifo_wvalid=0, busy=0, instr_addr=BOOT_ADDR. fifo_clear is 0 unless branch_req=1 in that cycle (combinational, see below).
- States: IDLE (instr_req=0), REQ (instr_req=1, waiting gnt).
- issue_ok = fetch_en & ~fifo_almost_full & (outstanding < MAX_OUTSTANDING) & ~branch_req.
- IDLE->REQ when issue_ok. REQ->IDLE on gnt unless issue_ok still true (then stay REQ for back-to-back requests, addr+4).
- Bus stability: once instr_req=1 with gnt=0, instr_req and instr_addr hold unchanged until gnt, regardless of fetch_en, almost_full or branch_req.
- On gnt: fetch_addr <= fetch_addr+4 (wraps modulo 2^ADDR_WIDTH), or branch target if a branch is pending/arriving; outstanding +1.
- instr_rvalid: outstanding -1; gnt and rvalid in the same cycle leave outstanding unchanged.
- Write path: fifo_wvalid = instr_rvalid & (discard==0) & ~branch_req; fifo_wdata = instr_rdata (zero added latency).
- discard decrements on each rvalid while nonzero.
- Branch (branch_req=1): fifo_clear=1 the same cycle (combinational). Registered update:
  - discard <= outstanding + (gnt granted this cycle) - (rvalid this cycle & discard==0 ? 0 : ...). Rule: every request granted on or before the branch cycle whose response arrives after the branch cycle is discarded. An rvalid in the branch cycle itself is dropped (not written).
  - If instr_req=0 or gnt=1 this cycle: fetch_addr <= {branch_addr[ADDR_WIDTH-1:2],2'b00}.
  - If instr_req=1 & gnt=0: set branch_pending and latch the target. On the later gnt, that request is added to discard and fetch_addr <= latched target; branch_pending clears.
  - A second branch while branch_pending: the latest target wins.
  - No request issues in the branch cycle.
- fetch_en low: REQ completes its handshake, then IDLE; responses still written.
- fifo_almost_full is trusted to leave room for MAX_OUTSTANDING words; responses are never back-pressured.
- Reset mid-operation clears all counters. Responses arriving after reset are the bus's responsibility (bus is reset too).

Test Plan:
- Reset, fetch_en=1, gnt always 1, rvalid 1 cycle after gnt -> instr_addr 0x80,0x84,0x88…; each rdata appears on fifo_wvalid the same cycle as rvalid; outstanding never exceeds MAX_OUTSTANDING=2.
- gnt held 0 for 3 cycles with branch_req pulsed during the stall -> instr_addr stays 0x80 until gnt; that response is discarded; next request uses the branch target 0x1000.
- Two granted outstanding (0x80,0x84), branch to 0x200 -> fifo_clear=1 one cycle; both responses dropped (fifo_wvalid=0); next written word comes from 0x200.
- fifo_almost_full=1 -> no new instr_req rises; in-flight responses still written; deasserting it resumes from the next sequential address.
- Branch in the same cycle as rvalid and gnt -> rvalid word not written; granted request discarded; discard count correct, busy drops when all drained.
- Address wrap: branch to 0xFFFF_FFFC -> following request address is 0x0000_0000.
